wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter and scoreboard feeding the register file's write port (we3/a3/wd3). Merges results from a single-cycle ALU source and a variable-latency memory/long-op source through a small FIFO, and commits at most one write per cycle. Tracks which architectural registers have an in-flight write so decode can stall on RAW/WAW hazards. Sits between the execute/memory stages and the register file.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- XLEN, 32, data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  ALU result valid
- a_rd  in  5  ALU destination register
- a_data  in  XLEN  ALU result
- a_ready  out  1  ALU result accepted when a_valid & a_ready at edge
- b_valid  in  1  memory/long-op result valid
- b_rd  in  5  memory/long-op destination register
- b_data  in  XLEN  memory/long-op result
- b_ready  out  1  memory/long-op result accepted when b_valid & b_ready at edge
- iss_valid  in  1  instruction issued with a register destination
- iss_rd  in  5  issued instruction's destination
- pending  out  32  bit r set = write to xr in flight
- we3  out  1  register file write enable (registered)
- a3  out  5  register file write address (registered)
- wd3  out  XLEN  register file write data (registered)

## Operation
- Reset: FIFO empty (count=0), pending=0, we3=0, a3=0, wd3=0.
- Readiness from start-of-cycle count only (pop in same cycle not credited):
  - a_ready = (count ≤ DEPTH-1).
  - b_ready = (count ≤ DEPTH-2) | (count == DEPTH-1 & !a_valid).
- Both accepted same edge: A enqueued first, then B (A is older).
- rd == 0: handshake completes, nothing enqueued, no write issued.
- Pop: if count > 0 at start of cycle, head loaded into we3/a3/wd3 at edge, we3=1; else we3=0 at edge. One pop per cycle max.
- Count update: count + pushes − pop; never exceeds DEPTH; pointers wrap mod DEPTH.
- Scoreboard:
  - set pending[iss_rd] at edge when iss_valid & iss_rd≠0.
  - clear pending[a3] at edge when we3=1 (cycle in which the register file captures).
  - set and clear of same bit same edge: set wins.
  - pending[0] always 0.
- Issue logic guarantees no second writer to a pending rd (single bit per register, no counting).

## Timing
- Result accepted at edge k with empty FIFO → we3=1, a3/wd3 valid during cycle after edge k+1; register file writes at edge k+2; pending bit clears at edge k+2.
- Back-to-back entries drain one per cycle, in FIFO order.
- Sustained throughput: one commit per cycle; input bursts of two per cycle absorbed up to DEPTH.
- rst asserted mid-operation: FIFO contents discarded, all outputs to reset values immediately (asynchronous); pending cleared.

## Configuration
- WB_STATS_EN defined: adds outputs stat_commits (32, count of cycles with we3=1) and stat_stalls (32, count of cycles with (a_valid & !a_ready) | (b_valid & !b_ready)); both reset to 0, wrap at 2^32.
- Undefined: those ports and counters are absent; all other behaviour identical.

## Test plan
- Reset: assert rst mid-burst with count=3 → we3=0, pending=0, a_ready=b_ready=1 next cycle after release.
- Single write: a_valid, a_rd=5, a_data=0xDEADBEEF at edge k, empty FIFO → we3=1, a3=5, wd3=0xDEADBEEF after edge k+1; pending[5] (set by iss earlier) clears at edge k+2.
- Dual accept: A(rd=1,0x11) and B(rd=2,0x22) same edge → commits rd=1 then rd=2 on consecutive cycles.
- Full: DEPTH=4, count=3, both valid → a_ready=1, b_ready=0; count=4 → both ready=0; drains to empty over 4 cycles with no loss or reorder.
- x0: a_rd=0 valid → a_ready=1, no we3 pulse, count unchanged.
- Scoreboard race: iss_valid iss_rd=7 same edge as we3=1 a3=7 → pending[7]=1 afterwards.

Source files
------------

// File: rtl/wb_if.sv
// wb_if: writeback bus bundle between execute/memory result sources, issue logic and wb_arbiter
interface wb_if #(
    parameter int XLEN = 32
);
    logic            a_valid;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            a_ready;
    logic            b_valid;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_data;
    logic            b_ready;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [31:0]     pending;
    logic            we3;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3;
    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd,
        input  a_ready, b_ready, pending, we3, a3, wd3
    );
    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data, iss_valid, iss_rd,
        output a_ready, b_ready, pending, we3, a3, wd3
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and memory results through a FIFO into the register file write port, with a pending-write scoreboard; WB_STATS_EN adds commit/stall counters
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input logic clk,
    input logic rst,
    wb_if.slave bus
`ifdef WB_STATS_EN
    ,
    output logic [31:0] stat_commits,
    output logic [31:0] stat_stalls
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] ROOM1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ROOM2 = CW'(DEPTH - 2);
    logic [CW-1:0]   count;
    logic [PW-1:0]   wp, rp, wp_b;
    logic [4:0]      rd_mem [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];
    logic            push_a, push_b, pop;
    logic [31:0]     pending_next;
    assign bus.a_ready = count <= ROOM1;
    assign bus.b_ready = (count <= ROOM2) | ((count == ROOM1) & !bus.a_valid);
    assign push_a = bus.a_valid & bus.a_ready & (bus.a_rd != 5'd0);
    assign push_b = bus.b_valid & bus.b_ready & (bus.b_rd != 5'd0);
    assign pop = count != '0;
    assign wp_b = wp + PW'(push_a);
    // scoreboard update: commit clears, issue sets afterwards so a same-edge set wins; x0 never pending
    always_comb begin
        pending_next = bus.pending;
        if (bus.we3) pending_next[bus.a3] = 1'b0;
        if (bus.iss_valid) pending_next[bus.iss_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end
    // FIFO storage: A takes the first free slot, B the one after it when both land together
    always_ff @(posedge clk) begin
        if (push_a) begin
            rd_mem[wp]   <= bus.a_rd;
            data_mem[wp] <= bus.a_data;
        end
        if (push_b) begin
            rd_mem[wp_b]   <= bus.b_rd;
            data_mem[wp_b] <= bus.b_data;
        end
    end
    // pointers, occupancy, registered write port and scoreboard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            wp          <= '0;
            rp          <= '0;
            bus.we3     <= 1'b0;
            bus.a3      <= '0;
            bus.wd3     <= '0;
            bus.pending <= '0;
        end else begin
            count       <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
            wp          <= wp_b + PW'(push_b);
            rp          <= rp + PW'(pop);
            bus.we3     <= pop;
            bus.pending <= pending_next;
            if (pop) begin
                bus.a3  <= rd_mem[rp];
                bus.wd3 <= data_mem[rp];
            end
        end
    end
`ifdef WB_STATS_EN
    logic stall;
    assign stall = (bus.a_valid & !bus.a_ready) | (bus.b_valid & !bus.b_ready);
    // free-running statistics, wrapping at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_commits <= '0;
            stat_stalls  <= '0;
        end else begin
            stat_commits <= stat_commits + 32'(bus.we3);
            stat_stalls  <= stat_stalls + 32'(stall);
        end
    end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    wb_if #(.XLEN(32)) bus();
`ifdef WB_STATS_EN
    logic [31:0] stat_commits, stat_stalls;
`endif
    wb_arbiter #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef WB_STATS_EN
        ,
        .stat_commits(stat_commits),
        .stat_stalls(stat_stalls)
`endif
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic drive_a(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.a_valid = v;
        bus.a_rd    = rd;
        bus.a_data  = d;
    endtask
    task automatic drive_b(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.b_valid = v;
        bus.b_rd    = rd;
        bus.b_data  = d;
    endtask
    initial begin
        rst = 1'b1;
        drive_a(0, 0, 0);
        drive_b(0, 0, 0);
        bus.iss_valid = 1'b0;
        bus.iss_rd    = 5'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_we3", bus.we3, 0);
        check("rst_a3", bus.a3, 0);
        check("rst_wd3", bus.wd3, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_a_ready", bus.a_ready, 1);
        check("rst_b_ready", bus.b_ready, 1);
`ifdef WB_STATS_EN
        check("rst_stat_commits", stat_commits, 0);
        check("rst_stat_stalls", stat_stalls, 0);
`endif
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd5;
        tick;
        bus.iss_valid = 1'b0;
        check("pend_set5", bus.pending, 32'h20);
        drive_a(1, 5, 32'hDEADBEEF);
        #1 check("single_a_ready", bus.a_ready, 1);
        tick;
        drive_a(0, 0, 0);
        check("single_no_early_we3", bus.we3, 0);
        tick;
        check("single_we3", bus.we3, 1);
        check("single_a3", bus.a3, 5);
        check("single_wd3", bus.wd3, 32'hDEADBEEF);
        check("single_pend_held", bus.pending, 32'h20);
        tick;
        check("single_pend_clr", bus.pending, 0);
        check("single_we3_off", bus.we3, 0);
        drive_a(1, 1, 32'h11);
        drive_b(1, 2, 32'h22);
        tick;
        drive_a(0, 0, 0);
        drive_b(0, 0, 0);
        tick;
        check("dual_we3_0", bus.we3, 1);
        check("dual_a3_0", bus.a3, 1);
        check("dual_wd3_0", bus.wd3, 32'h11);
        tick;
        check("dual_we3_1", bus.we3, 1);
        check("dual_a3_1", bus.a3, 2);
        check("dual_wd3_1", bus.wd3, 32'h22);
        tick;
        check("dual_idle", bus.we3, 0);
        drive_a(1, 1, 32'h101);
        drive_b(1, 2, 32'h102);
        tick;
        drive_a(1, 3, 32'h103);
        drive_b(1, 4, 32'h104);
        tick;
        check("full_a3_1", bus.a3, 1);
        drive_a(1, 5, 32'h105);
        drive_b(1, 6, 32'h106);
        #1;
        check("full3_a_ready", bus.a_ready, 1);
        check("full3_b_ready", bus.b_ready, 0);
        tick;
        drive_a(0, 0, 0);
        #1;
        check("full3_b_ready_alone", bus.b_ready, 1);
        check("full_a3_2", bus.a3, 2);
        check("full_wd3_2", bus.wd3, 32'h102);
        tick;
        drive_b(0, 0, 0);
        for (int i = 3; i <= 6; i++) begin
            check("full_drain_we3", bus.we3, 1);
            check("full_drain_a3", bus.a3, 64'(i));
            check("full_drain_wd3", bus.wd3, 64'(32'h100 + i));
            tick;
        end
        check("full_empty", bus.we3, 0);
        drive_a(1, 0, 32'h55);
        #1 check("x0_a_ready", bus.a_ready, 1);
        tick;
        drive_a(0, 0, 0);
        check("x0_no_we3_a", bus.we3, 0);
        tick;
        check("x0_no_we3_b", bus.we3, 0);
        check("x0_pending", bus.pending, 0);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd7;
        tick;
        bus.iss_valid = 1'b0;
        drive_a(1, 7, 32'h77);
        tick;
        drive_a(0, 0, 0);
        tick;
        check("race_we3", bus.we3, 1);
        check("race_a3", bus.a3, 7);
        check("race_pend_pre", bus.pending, 32'h80);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd7;
        tick;
        bus.iss_valid = 1'b0;
        check("race_set_wins", bus.pending, 32'h80);
        tick;
        check("race_pend_hold", bus.pending, 32'h80);
        check("race_we3_off", bus.we3, 0);
        bus.iss_valid = 1'b1;
        bus.iss_rd    = 5'd0;
        tick;
        bus.iss_valid = 1'b0;
        check("x0_never_pending", bus.pending, 32'h80);
        drive_a(1, 1, 32'h1);
        drive_b(1, 2, 32'h2);
        tick;
        drive_a(1, 3, 32'h3);
        drive_b(1, 4, 32'h4);
        tick;
        check("burst_we3", bus.we3, 1);
        #2 rst = 1'b1;
        #1;
        check("async_we3", bus.we3, 0);
        check("async_a3", bus.a3, 0);
        check("async_wd3", bus.wd3, 0);
        check("async_pending", bus.pending, 0);
        drive_a(0, 0, 0);
        drive_b(0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("post_rst_a_ready", bus.a_ready, 1);
        check("post_rst_b_ready", bus.b_ready, 1);
        tick;
        check("post_rst_empty", bus.we3, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
